// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
//
// Frame controller for a chain of dual-core wavelet blocks sharing a single
// read-out bus. Each frame runs an integration window (ud_en high), a guard
// interval, then reads every core out beat by beat. Each captured beat is
// forwarded to the RISC side over a valid/ready stream.
//
// Ports
//   clk_master            single clock
//   rstb                  asynchronous active-low reset
//   start                 begin a frame (only honoured in IDLE)
//   cont_mode             at DONE: 1 = next frame at once, 0 = back to IDLE
//   abort                 synchronous return to IDLE from any state
//   integ_len             integration length in cycles (0 behaves as 1)
//   ud_en                 count enable to all cores
//   rd_sel                one-hot select of the core driving the bus
//   rd_shift              one-cycle advance strobe to the selected core
//   read_out_I/Q          shared read-out bus from the cores
//   out_valid/out_ready   stream handshake
//   out_I/out_Q           captured bus bits
//   out_core              index of the core that produced the beat
//   out_last              marks the final beat of the frame
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module readout_sequencer #(
  parameter int NUM_CORES    = 8,
  parameter int CORE_W       = 3,
  parameter int WORD_LEN     = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                 clk_master,
  input  logic                 rstb,
  input  logic                 start,
  input  logic                 cont_mode,
  input  logic                 abort,
  input  logic [15:0]          integ_len,
  output logic                 ud_en,
  output logic [NUM_CORES-1:0] rd_sel,
  output logic                 rd_shift,
  input  logic [1:0]           read_out_I,
  input  logic [1:0]           read_out_Q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_I,
  output logic [1:0]           out_Q,
  output logic [CORE_W-1:0]    out_core,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int BEAT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORD_LEN - 1);
  localparam logic [CORE_W-1:0] LAST_CORE  = CORE_W'(NUM_CORES - 1);
  localparam logic [15:0]       GUARD_LOAD = 16'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INTEG, GUARD, SEL, CAP, HOLD, SHIFT, DONE
  } state_t;

  state_t              state;
  logic [15:0]         cnt;
  logic [CORE_W-1:0]   k;
  logic [BEAT_W-1:0]   beat;

  // A zero integration length still gives one cycle of ud_en.
  function automatic logic [15:0] integ_load(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [CORE_W-1:0] idx);
    return NUM_CORES'(1) << idx;
  endfunction

  // All outputs are registered and updated together with the state, so each
  // output is asserted exactly during the state(s) it belongs to.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      beat      <= '0;
      ud_en     <= 1'b0;
      rd_sel    <= '0;
      rd_shift  <= 1'b0;
      out_valid <= 1'b0;
      out_I     <= '0;
      out_Q     <= '0;
      out_core  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // Abort overrides everything, including a handshake in HOLD: the
      // pending beat is dropped and no shift strobe is issued.
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      beat      <= '0;
      ud_en     <= 1'b0;
      rd_sel    <= '0;
      rd_shift  <= 1'b0;
      out_valid <= 1'b0;
      out_I     <= '0;
      out_Q     <= '0;
      out_core  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= INTEG;
            cnt   <= integ_load(integ_len);
            k     <= '0;
            beat  <= '0;
            ud_en <= 1'b1;
            busy  <= 1'b1;
          end
        end

        INTEG: begin
          if (cnt == 16'd1) begin
            state <= GUARD;
            cnt   <= GUARD_LOAD;
            ud_en <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        GUARD: begin
          if (cnt == 16'd1) begin
            state  <= SEL;
            rd_sel <= onehot(k);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        // One settle cycle with the new core on the bus before capturing.
        SEL: state <= CAP;

        CAP: begin
          out_I     <= read_out_I;
          out_Q     <= read_out_Q;
          out_core  <= k;
          out_last  <= (k == LAST_CORE) && (beat == LAST_BEAT);
          out_valid <= 1'b1;
          state     <= HOLD;
        end

        // out_valid is always high here, so out_ready alone completes the
        // handshake; data stays frozen for as long as the sink stalls.
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_shift  <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          rd_shift <= 1'b0;
          if (beat < LAST_BEAT) begin
            beat  <= beat + 1'b1;
            state <= CAP;
          end else if (k < LAST_CORE) begin
            beat   <= '0;
            k      <= k + 1'b1;
            rd_sel <= onehot(k + 1'b1);
            state  <= SEL;
          end else begin
            rd_sel <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (cont_mode) begin
            state <= INTEG;
            cnt   <= integ_load(integ_len);
            k     <= '0;
            beat  <= '0;
            ud_en <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_readout_sequencer
//
// Bench for readout_sequencer with 2 cores, 4 beats per core, 2 guard cycles.
// A behavioural core array answers rd_sel/rd_shift from per-core word
// memories; expected beats come from those memories in frame order, and frame
// timing comes from the closed-form frame length plus observed stall cycles.
// ---------------------------------------------------------------------------
module tb_readout_sequencer;

  localparam int N    = 2;
  localparam int CW   = 1;
  localparam int W    = 4;
  localparam int G    = 2;
  localparam int BASE = G + N * (1 + 3 * W) + 1;  // frame length minus L

  typedef struct packed {
    logic [1:0]    i;
    logic [1:0]    q;
    logic [CW-1:0] core;
    logic          last;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    int          stall_beat;  // 1-based beat to stall, 0 = none
    int          stall_len;
    bit          guard_start;
    int          exp_ud;
    int          exp_frame;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          cont_mode = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   integ_len = '0;
  logic          out_ready = 1'b0;
  logic [1:0]    read_out_I, read_out_Q;
  logic          ud_en, rd_shift, out_valid, out_last, busy, done;
  logic [N-1:0]  rd_sel;
  logic [1:0]    out_I, out_Q;
  logic [CW-1:0] out_core;

  int vectors = 0;
  int miscompares = 0;

  readout_sequencer #(
    .NUM_CORES(N), .CORE_W(CW), .WORD_LEN(W), .GUARD_CYCLES(G)
  ) dut (
    .clk_master(clk), .rstb(rstb), .start(start), .cont_mode(cont_mode),
    .abort(abort), .integ_len(integ_len), .ud_en(ud_en), .rd_sel(rd_sel),
    .rd_shift(rd_shift), .read_out_I(read_out_I), .read_out_Q(read_out_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I),
    .out_Q(out_Q), .out_core(out_core), .out_last(out_last), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural core array: each core presents word[ptr] while selected and
  // advances on rd_shift; integration reloads every readout pointer.
  logic [3:0] mem [N][W];
  int         ptr [N];
  logic [3:0] bus_bits;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ud_en) ptr[i] <= 0;
      else if (rd_shift && rd_sel[i]) ptr[i] <= ptr[i] + 1;
    end
  end

  always_comb begin
    bus_bits = 4'b0;
    for (int i = 0; i < N; i++)
      if (rd_sel[i] && ptr[i] >= 0 && ptr[i] < W) bus_bits = mem[i][ptr[i]];
  end
  assign read_out_I = bus_bits[3:2];
  assign read_out_Q = bus_bits[1:0];

  beat_t expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fill the core memories and the expected beat queue for one frame.
  task automatic load_data(input bit rnd);
    beat_t e;
    expq.delete();
    for (int c = 0; c < N; c++) begin
      for (int b = 0; b < W; b++) begin
        mem[c][b] = rnd ? 4'($urandom) : 4'(c * W + b);
        e.i    = mem[c][b][3:2];
        e.q    = mem[c][b][1:0];
        e.core = CW'(c);
        e.last = (c == N - 1) && (b == W - 1);
        expq.push_back(e);
      end
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({ud_en, rd_sel, rd_shift, out_valid, out_I, out_Q, out_core,
                out_last, busy, done});
  endfunction

  // Runs one frame from the current negedge up to and including the DONE
  // cycle. ready_mode: 1 = ready except for a stall window, 2 = random.
  task automatic run_frame(input logic [15:0] len, input bit do_start,
                           input int ready_mode, input int stall_beat,
                           input int stall_len, input bit guard_start,
                           input bit next_cont, input logic [15:0] next_len,
                           output int ud_cnt, output int frame_len,
                           output int stalls);
    int    cyc, first_sel, shifts, hs_cnt, hold_cnt, errs;
    bit    prev_hs, prev_stall, hs, stall, got_done;
    beat_t cur, held, e;
    cyc = 0; ud_cnt = 0; frame_len = 0; stalls = 0; first_sel = 0;
    shifts = 0; hs_cnt = 0; hold_cnt = 0; errs = 0;
    prev_hs = 0; prev_stall = 0; got_done = 0; held = '0;
    if (do_start) begin
      integ_len = len;
      start = 1'b1;
    end
    for (int t = 0; t < 3000 && !got_done; t++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      cur = {out_I, out_Q, out_core, out_last};
      if (cyc == 1) check("ud_en first frame cycle", 64'(ud_en), 64'd1);
      if (cyc == 2) integ_len = 16'($urandom_range(0, 40));
      if (ud_en) begin
        ud_cnt++;
        if (ud_cnt != cyc) errs++;
        if (rd_sel != '0) errs++;
      end
      if (rd_sel != '0) begin
        if (first_sel == 0) first_sel = cyc;
        if ((rd_sel & (rd_sel - 1'b1)) != '0) errs++;
      end
      if (rd_shift) shifts++;
      if (rd_shift != prev_hs) errs++;
      if (prev_stall && (!out_valid || cur != held)) errs++;
      if (!busy) errs++;
      if (guard_start) start = !ud_en && (first_sel == 0);
      if (ready_mode == 1)
        out_ready = !(out_valid && (hs_cnt + 1 == stall_beat) && (hold_cnt < stall_len));
      else
        out_ready = ($urandom_range(0, 3) != 0);
      hs    = out_valid && out_ready;
      stall = out_valid && !out_ready;
      if (stall) begin
        stalls++;
        hold_cnt++;
        held = cur;
      end
      if (hs) begin
        if (expq.size() == 0) errs++;
        else begin
          e = expq.pop_front();
          check("beat data", 64'(cur), 64'(e));
        end
        hs_cnt++;
      end
      prev_hs    = hs;
      prev_stall = stall;
      if (done) begin
        got_done  = 1;
        frame_len = cyc;
        if (rd_sel != '0 || out_valid) errs++;
        cont_mode = next_cont;
        integ_len = next_len;
        start     = 1'b0;
      end
    end
    check("done within budget", 64'(got_done), 64'd1);
    check("frame protocol errors", 64'(errs), 64'd0);
    check("guard gap", 64'(first_sel), 64'(ud_cnt + G + 1));
    check("rd_shift count", 64'(shifts), 64'(N * W));
    check("beats delivered", 64'(hs_cnt), 64'(N * W));
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, all_outputs() & 64'(2'b11), 64'd0);  // busy and done low
  endtask

  vec_t tbl[4];

  initial begin
    int ud, fl, st, lmax, hs_cnt, zerr;
    bit found;
    tbl[0] = '{16'd10, 0, 0, 1'b0, 10, 39};
    tbl[1] = '{16'd10, 3, 5, 1'b0, 10, 44};
    tbl[2] = '{16'd0,  0, 0, 1'b0, 1,  30};
    tbl[3] = '{16'd3,  0, 0, 1'b1, 3,  32};

    // Reset state
    repeat (3) @(negedge clk);
    check("outputs in reset", all_outputs(), 64'd0);
    rstb = 1'b1;
    @(negedge clk);
    check("outputs after reset", all_outputs(), 64'd0);

    // Directed frames from the table, beat-index data pattern
    for (int v = 0; v < 4; v++) begin
      load_data(1'b0);
      run_frame(tbl[v].len, 1'b1, 1, tbl[v].stall_beat, tbl[v].stall_len,
                tbl[v].guard_start, 1'b0, 16'd0, ud, fl, st);
      check("table ud_en cycles", 64'(ud), 64'(tbl[v].exp_ud));
      check("table frame length", 64'(fl), 64'(tbl[v].exp_frame));
      check("table stall cycles", 64'(st), 64'(tbl[v].stall_len));
      check_idle("idle after done");
    end

    // Continuous mode: second frame starts right after DONE
    load_data(1'b1);
    run_frame(16'd5, 1'b1, 1, 0, 0, 1'b0, 1'b1, 16'd7, ud, fl, st);
    check("cont frame1 length", 64'(fl), 64'(5 + BASE));
    load_data(1'b1);
    run_frame(16'd0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 16'd0, ud, fl, st);
    check("cont frame2 ud_en cycles", 64'(ud), 64'd7);
    check("cont frame2 length", 64'(fl), 64'(7 + BASE));
    check_idle("idle after cont frames");

    // Randomized frames: random length, data and back-pressure
    for (int r = 0; r < 6; r++) begin
      logic [15:0] len;
      len  = 16'($urandom_range(0, 20));
      lmax = (len == 0) ? 1 : int'(len);
      load_data(1'b1);
      run_frame(len, 1'b1, 2, 0, 0, 1'b0, 1'b0, 16'd0, ud, fl, st);
      check("random ud_en cycles", 64'(ud), 64'(lmax));
      check("random frame length", 64'(fl), 64'(lmax + BASE + st));
      check_idle("idle after random frame");
    end

    // Abort in HOLD of core 1 beat 2, together with out_ready
    load_data(1'b1);
    integ_len = 16'd4;
    start = 1'b1;
    hs_cnt = 0;
    found = 0;
    for (int t = 0; t < 500 && !found; t++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b1;
      if (out_valid) begin
        if (hs_cnt == W + 2) begin
          found = 1;
          check("abort point core", 64'(out_core), 64'd1);
          abort = 1'b1;
        end else begin
          hs_cnt++;
        end
      end
    end
    check("abort point reached", 64'(found), 64'd1);
    @(negedge clk);
    abort = 1'b0;
    check("outputs after abort", all_outputs(), 64'd0);
    zerr = 0;
    repeat (4) begin
      @(negedge clk);
      if (all_outputs() != 64'd0) zerr++;
    end
    check("stays idle after abort", 64'(zerr), 64'd0);
    load_data(1'b0);
    run_frame(16'd2, 1'b1, 1, 0, 0, 1'b0, 1'b0, 16'd0, ud, fl, st);
    check("frame after abort length", 64'(fl), 64'(2 + BASE));
    check_idle("idle after post-abort frame");

    // Asynchronous reset in the middle of integration
    integ_len = 16'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ud_en before async reset", 64'(ud_en), 64'd1);
    @(posedge clk);
    #2 rstb = 1'b0;
    #1 check("ud_en drops on async reset", 64'(ud_en), 64'd0);
    check("busy drops on async reset", 64'(busy), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("outputs after async reset", all_outputs(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Controller for a chain of dual-core wavelet blocks that share one read-out bus.
- Sequences each measurement frame in order: integration window (ud_en high), guard interval, then core-by-core readout.
- During readout, asserts a one-hot core select and pulses a shift strobe to the selected core.
- Forwards the shared read_out_I/read_out_Q bits to the RISC side over a valid/ready stream.
- Sits between the RISC interface and the core array, in the clk_master domain.

Parameters:
NUM_CORES, 8, number of wavelet cores on the shared read-out bus (≥2)
CORE_W, 3, width of core index, ≥ clog2(NUM_CORES)
WORD_LEN, 16, beats shifted out per core per frame (≥1)
GUARD_CYCLES, 4, clk_master cycles with ud_en low between integration and readout (≥1)

Ports:
clk_master  in  1  single clock
rstb  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled in IDLE only
cont_mode  in  1  at DONE: 1 = start next frame immediately, 0 = return to IDLE
abort  in  1  synchronous; return to IDLE from any state
integ_len  in  16  integration length in cycles; latched on accepted start; 0 treated as 1
ud_en  out  1  count enable to all cores
rd_sel  out  NUM_CORES  one-hot core select for shared read-out bus
rd_shift  out  1  one-cycle advance strobe to selected core's readout register
read_out_I  in  2  shared bus from cores
read_out_Q  in  2  shared bus from cores
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_I  out  2  captured I bits
out_Q  out  2  captured Q bits
out_core  out  CORE_W  index of core that produced beat
out_last  out  1  high with final beat of frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (rstb low, async), all outputs 0:
  - ud_en, rd_sel, rd_shift, out_valid, out_I, out_Q, out_core, out_last, busy, done.
  - State IDLE; counters k (core), beat, cnt cleared.
- All outputs are registered.
- States: IDLE, INTEG, GUARD, SEL, CAP, HOLD, SHIFT, DONE.
- IDLE:
  - start=1 → INTEG; cnt ← max(integ_len,1); k ← 0; beat ← 0.
  - start while busy is ignored.
- INTEG:
  - ud_en=1 for exactly max(integ_len,1) cycles.
  - cnt decrements each cycle; at cnt==1 → GUARD.
- GUARD:
  - ud_en=0 for GUARD_CYCLES cycles → SEL.
- SEL:
  - rd_sel=1<<k for one settle cycle, no capture → CAP.
- CAP:
  - out_I←read_out_I, out_Q←read_out_Q, out_core←k.
  - out_last←(k==NUM_CORES-1 && beat==WORD_LEN-1).
  - out_valid←1 → HOLD.
- HOLD:
  - out_valid and data held stable while out_ready=0; no timeout.
  - On out_valid&&out_ready: out_valid←0, out_last←0 → SHIFT.
- SHIFT:
  - rd_shift=1 for exactly this cycle.
  - If beat<WORD_LEN-1: beat++ → CAP.
  - Else if k<NUM_CORES-1: beat←0, k++ → SEL.
  - Else → DONE.
- rd_sel is held constant from SEL through SHIFT of the same core, and is 0 in IDLE/INTEG/GUARD/DONE.
- Exactly one rd_sel bit high when nonzero.
- DONE:
  - done=1 for one cycle.
  - cont_mode=1 → INTEG with cnt←max(integ_len latched at this DONE,1), k,beat←0.
  - cont_mode=0 → IDLE.
- Minimum beat period is 3 cycles (CAP, HOLD, SHIFT).
- Frame length with out_ready tied high: L+GUARD_CYCLES+NUM_CORES*(1+3*WORD_LEN)+1 cycles, where L=max(integ_len,1).
- abort=1 (any state, takes priority over start and handshake):
  - Next state IDLE; all outputs return to reset values next cycle.
  - A beat pending in HOLD is dropped.
  - No rd_shift is issued.
- Simultaneous out_ready and abort: abort wins, handshake not counted.
- busy=1 from the cycle after start is accepted until the cycle after DONE (stays 1 if cont_mode).
- integ_len changes mid-frame have no effect until the next latch.

Test Plan:
- NUM_CORES=2, WORD_LEN=4, GUARD=2, integ_len=10, out_ready=1, start pulse:
  - ud_en high exactly 10 cycles, then 2 low cycles before rd_sel=2'b01.
  - 8 beats total, out_core 0,0,0,0,1,1,1,1; out_last only on beat 8.
  - done pulses 39 cycles after INTEG entry.
- Drive read_out_I/Q per beat with pattern {I,Q}=beat index:
  - out_I/out_Q match the value present in each CAP cycle.
  - rd_shift pulses 8 times, each one cycle after a handshake.
- out_ready low 5 cycles on beat 3:
  - out_valid and data stable for 5 cycles.
  - No rd_shift until the handshake.
  - Frame extends by exactly 5 cycles.
- integ_len=0 → ud_en high exactly 1 cycle.
- cont_mode=1 → second frame's ud_en rises the cycle after done, with no IDLE gap.
- abort asserted in HOLD of core 1 beat 2:
  - Next cycle all outputs 0, state IDLE, no done pulse.
  - A fresh start then runs a full frame beginning at core 0.
- rstb low mid-INTEG (async): ud_en drops immediately without waiting for a clk_master edge.
- start asserted during GUARD: ignored, and the frame timing is unchanged.
